ram_bus_arbiter2: RTL

Two-master to one-slave arbiter for the req/we/addr/be/wdata/ack/resp/rdata memory bus. It lets two requesters, such as a CPU instruction port and a data port, share a single-port RAM slave. Grants between the masters are round-robin. An in-order FIFO of master IDs routes each read response back to the master that issued the read. Non-posted reads, posted writes.

---
 rtl/ram_bus_pkg.sv | 14 +
 rtl/ram_bus_id_fifo.sv | 60 ++++++
 rtl/ram_bus_arbiter2.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ram_bus_pkg.sv
// Shared definitions for the req/we/addr/be/wdata/ack/resp/rdata memory bus.
package ram_bus_pkg;

    // Default bus field widths
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Identifies which master issued a transaction
    typedef logic master_id_t;

    localparam master_id_t MASTER0 = 1'b0;
    localparam master_id_t MASTER1 = 1'b1;

endpackage

// File: rtl/ram_bus_id_fifo.sv
// Small synchronous FIFO with an occupancy count. It holds the master IDs of
// outstanding reads, in issue order.
module ram_bus_id_fifo #(
    parameter int DEPTH = 4,
    parameter int LOG   = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LOG:0]     count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LOG-1:0]   wr_ptr;
    logic [LOG-1:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (LOG+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage, pointers and count; pointers wrap naturally since DEPTH is 2**LOG
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            // NOTE: the storage is only DEPTH single-bit flops, so clearing it on
            // reset is cheap; larger memories would normally be left unreset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees the values
            // from before this edge, regardless of statement order.
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + LOG'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + LOG'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (LOG+1)'(1);
                2'b01:   count <= count - (LOG+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_bus_arbiter2.sv
// Two-master to one-slave round-robin arbiter. Reads are non-posted: the ID of
// each accepted read is queued and used to route the in-order response back.
module ram_bus_arbiter2
    import ram_bus_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int OUTST_DEPTH = 4,
    parameter int OUTST_LOG   = 2
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_bi,
    input  logic [DATA_W/8-1:0] m0_be_bi,
    input  logic [DATA_W-1:0]   m0_wdata_bi,
    output logic                m0_ack_o,
    output logic                m0_resp_o,
    output logic [DATA_W-1:0]   m0_rdata_bo,
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_bi,
    input  logic [DATA_W/8-1:0] m1_be_bi,
    input  logic [DATA_W-1:0]   m1_wdata_bi,
    output logic                m1_ack_o,
    output logic                m1_resp_o,
    output logic [DATA_W-1:0]   m1_rdata_bo,
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_bo,
    output logic [DATA_W/8-1:0] s_be_bo,
    output logic [DATA_W-1:0]   s_wdata_bo,
    input  logic                s_ack_i,
    input  logic                s_resp_i,
    input  logic [DATA_W-1:0]   s_rdata_bi,
    output logic                err_o
);

    master_id_t         prio;
    master_id_t         gnt_id;
    logic               gnt_valid;
    logic               rd_block;
    logic               accept;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    master_id_t         head_id;
    logic [OUTST_LOG:0] fifo_count;

    // Grant selection and slave-side mux; without a grant master 0 drives the fields
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned,
        // which would otherwise infer a latch.
        gnt_valid  = m0_req_i | m1_req_i;
        gnt_id     = MASTER0;
        s_we_o     = m0_we_i;
        s_addr_bo  = m0_addr_bi;
        s_be_bo    = m0_be_bi;
        s_wdata_bo = m0_wdata_bi;
        if (m0_req_i && m1_req_i) begin
            gnt_id = prio;
        end else if (m1_req_i) begin
            gnt_id = MASTER1;
        end
        if (gnt_id == MASTER1) begin
            s_we_o     = m1_we_i;
            s_addr_bo  = m1_addr_bi;
            s_be_bo    = m1_be_bi;
            s_wdata_bo = m1_wdata_bi;
        end
    end

    // A read is held off while the ID queue is full (registered count, so a
    // same-cycle pop does not help); the grant is not handed to the other master.
    // Requests are suppressed outright while reset is asserted.
    assign rd_block = gnt_valid & ~s_we_o & fifo_full;
    assign s_req_o  = gnt_valid & ~rd_block & rstn_i;
    assign accept   = s_req_o & s_ack_i;
    assign m0_ack_o = accept & (gnt_id == MASTER0);
    assign m1_ack_o = accept & (gnt_id == MASTER1);

    // Response demux: the queue head names the master that issued this read
    assign fifo_pop    = s_resp_i & ~fifo_empty;
    assign m0_resp_o   = fifo_pop & (head_id == MASTER0);
    assign m1_resp_o   = fifo_pop & (head_id == MASTER1);
    assign m0_rdata_bo = s_rdata_bi;
    assign m1_rdata_bo = s_rdata_bi;

    // Round-robin priority moves only on an accept, so a stalled master keeps its turn
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prio <= MASTER0;
        end else if (accept) begin
            prio <= ~gnt_id;
        end
    end

    // Sticky error: a slave response arrived with no read outstanding
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_o <= 1'b0;
        end else if (s_resp_i && fifo_empty) begin
            err_o <= 1'b1;
        end
    end

    ram_bus_id_fifo #(
        .DEPTH (OUTST_DEPTH),
        .LOG   (OUTST_LOG),
        .WIDTH (1)
    ) u_id_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .push   (accept & ~s_we_o),
        .din    (gnt_id),
        .pop    (fifo_pop),
        .dout   (head_id),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

endmodule
